// File: rtl/sad_pkg.sv
// Shared types and sizing helpers for the SAD datapath.
// Imported by the abs-diff stage and the block accumulator.
package sad_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int BLK_N_DEF = 16;

  function automatic int sad_sum_w(input int pix_w, input int blk_n);
    return pix_w + $clog2(blk_n);
  endfunction

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/abs_diff.sv
// Combinational |a-b| for unsigned pixels.
// Negative differences are folded back with a two's-complement negate.
module abs_diff
  import sad_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] abs
);

  logic [PIX_W:0]   diff;
  logic [PIX_W-1:0] neg;

  assign diff = {1'b0, a} - {1'b0, b};
  // Only the low bits of ~diff+1 survive, so the sign bit is not needed.
  assign neg  = ~diff[PIX_W-1:0] + {{(PIX_W-1){1'b0}}, 1'b1};
  assign abs  = diff[PIX_W] ? neg : diff[PIX_W-1:0];

endmodule

// File: rtl/sad_block_accumulator.sv
// Per-block sum of absolute differences over BLK_N pixel pairs.
// Two-stage pipe: registered |a-b|, then accumulate; result on valid/ready.
module sad_block_accumulator
  import sad_pkg::*;
#(
  parameter  int PIX_W = PIX_W_DEF,
  parameter  int BLK_N = BLK_N_DEF,
  localparam int SUM_W = sad_sum_w(PIX_W, BLK_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pix_a,
  input  logic [PIX_W-1:0] pix_b,
  output logic             sad_valid,
  input  logic             sad_ready,
  output logic [SUM_W-1:0] sad_sum
);

  localparam int CNT_W = $clog2(BLK_N) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLK_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic             started;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] acc_cnt;
  logic [PIX_W-1:0] abs_v;
  logic [PIX_W-1:0] d_q;
  logic             d_v;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_nxt;
  logic             accept;
  logic             hs;

  abs_diff #(.PIX_W(PIX_W)) u_abs (
    .a   (pix_a),
    .b   (pix_b),
    .abs (abs_v)
  );

  assign in_ready = started && (state == ACC)
                 && (in_cnt != CNT_FULL);
  assign accept   = in_valid && in_ready;
  assign hs       = sad_valid && sad_ready;
  assign acc_nxt  = acc + SUM_W'(d_q);

  // Holds input closed until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) started <= 1'b0;
    else        started <= 1'b1;
  end

  // Stage 1: register |a-b| and count pairs taken this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= '0;
      d_v    <= 1'b0;
      in_cnt <= '0;
    end else if (clr) begin
      d_v    <= 1'b0;
      in_cnt <= '0;
    end else begin
      d_v <= accept;
      if (accept) d_q <= abs_v;
      if (hs)          in_cnt <= '0;
      else if (accept) in_cnt <= in_cnt + CNT_ONE;
    end
  end

  // Stage 2 and block FSM: accumulate, publish, wait for handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      acc_cnt   <= '0;
      sad_valid <= 1'b0;
      sad_sum   <= '0;
    end else if (clr) begin
      state     <= ACC;
      acc       <= '0;
      acc_cnt   <= '0;
      sad_valid <= 1'b0;
    end else begin
      unique case (state)
        ACC: begin
          if (d_v) begin
            acc     <= acc_nxt;
            acc_cnt <= acc_cnt + CNT_ONE;
            if (acc_cnt == CNT_LAST) begin
              sad_sum   <= acc_nxt;
              sad_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (sad_ready) begin
            acc       <= '0;
            acc_cnt   <= '0;
            sad_valid <= 1'b0;
            state     <= ACC;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_block_accumulator.sv
// Bench for sad_block_accumulator: behavioural block model,
// per-cycle compare, directed blocks plus randomized traffic.
module tb_sad_block_accumulator;

  localparam int PIX_W = 8;
  localparam int BLK_N = 16;
  localparam int SUM_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] pix_a = '0;
  logic [PIX_W-1:0] pix_b = '0;
  logic             sad_valid;
  logic             sad_ready = 1'b1;
  logic [SUM_W-1:0] sad_sum;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  sad_block_accumulator #(
    .PIX_W(PIX_W),
    .BLK_N(BLK_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pix_a     (pix_a),
    .pix_b     (pix_b),
    .sad_valid (sad_valid),
    .sad_ready (sad_ready),
    .sad_sum   (sad_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Block-level model: pairs taken, running sum, result slot.
  bit m_started = 0;
  int m_cnt = 0;
  int m_sum = 0;
  bit m_pend = 0;
  bit m_valid = 0;
  int m_out = 0;
  bit m_acc_evt = 0;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit m_ready();
    return m_started && !m_valid && !m_pend && (m_cnt < BLK_N);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 0; m_cnt = 0; m_sum = 0;
      m_pend = 0; m_valid = 0; m_out = 0;
      m_acc_evt = 0;
    end else begin
      automatic bit take = in_valid && m_ready();
      m_acc_evt = take && !clr;
      m_started = 1;
      if (clr) begin
        m_cnt = 0; m_sum = 0; m_pend = 0; m_valid = 0;
      end else begin
        if (m_valid && sad_ready) begin
          m_valid = 0; m_cnt = 0; m_sum = 0;
        end
        if (m_pend) begin
          m_valid = 1; m_out = m_sum; m_pend = 0;
        end
        if (take) begin
          m_sum += absd(int'(pix_a), int'(pix_b));
          m_cnt++;
          if (m_cnt == BLK_N) m_pend = 1;
        end
      end
    end
  end

  int got[$];

  // Compare DUT against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", in_ready, m_ready());
      chk("sad_valid", sad_valid, m_valid);
      if (m_valid) chk("sad_sum", sad_sum, m_out);
      if (rst_n && sad_valid && sad_ready && !clr)
        got.push_back(int'(sad_sum));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_pair(input int a, input int b);
    int n;
    pix_a = PIX_W'(a);
    pix_b = PIX_W'(b);
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_acc_evt && n < 100);
    if (n >= 100) chk("accept_timeout", n, 0);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int a, input int b);
    for (int i = 0; i < BLK_N; i++) send_pair(a, b);
  endtask

  task automatic expect_result(input string nm, input int exp);
    int n;
    n = 0;
    while (got.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    if (got.size() == 0) chk({nm, "_timeout"}, 0, 1);
    else chk(nm, got.pop_front(), exp);
  endtask

  initial begin
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sad_valid", sad_valid, 0);
    chk("rst_sad_sum", sad_sum, 0);
    rst_n = 1'b1;

    // Back-to-back block, then the exact result timing.
    send_block(10, 3);
    chk("lat_not_yet", sad_valid, 0);
    tick();
    chk("lat_valid", sad_valid, 1);
    tick();
    chk("lat_one_cycle", sad_valid, 0);
    expect_result("blk_10_3", 112);

    send_block(3, 10);
    expect_result("blk_3_10", 112);
    send_block(255, 0);
    expect_result("blk_255_0", 4080);
    send_block(77, 77);
    expect_result("blk_77_77", 0);

    // Mixed block with in_valid toggling.
    for (int i = 0; i < BLK_N; i++) begin
      send_pair(i, 15 - i);
      tick();
    end
    expect_result("blk_mixed", 128);

    // Consumer stall while DONE.
    sad_ready = 1'b0;
    send_block(10, 3);
    for (int n = 0; n < 20 && !m_valid; n++) tick();
    pix_a = 8'd1;
    pix_b = 8'd0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", sad_valid, 1);
      chk("stall_sum", sad_sum, 112);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    sad_ready = 1'b1;
    expect_result("blk_stall", 112);
    send_block(1, 0);
    expect_result("blk_1_0", 16);

    // Abort a partial block with clr.
    for (int i = 0; i < 7; i++) send_pair(9, 1);
    clr = 1'b1;
    pix_a = 8'd9;
    pix_b = 8'd1;
    in_valid = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    send_block(2, 0);
    expect_result("blk_after_clr", 32);
    repeat (5) tick();
    chk("clr_single_result", got.size(), 0);

    // Asynchronous reset mid-block.
    for (int i = 0; i < 7; i++) send_pair(9, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_sad_valid", sad_valid, 0);
    chk("arst_sad_sum", sad_sum, 0);
    tick();
    rst_n = 1'b1;
    send_block(2, 0);
    expect_result("blk_after_rst", 32);
    repeat (5) tick();
    chk("rst_single_result", got.size(), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      sad_ready = ($urandom_range(2) != 0);
      clr       = ($urandom_range(99) == 0);
      case ($urandom_range(3))
        0: begin pix_a = 8'd255; pix_b = 8'd0; end
        1: begin pix_a = 8'd0; pix_b = 8'd255; end
        default: begin
          pix_a = PIX_W'($urandom);
          pix_b = PIX_W'($urandom);
        end
      endcase
      tick();
    end
    in_valid = 1'b0;
    clr = 1'b0;
    sad_ready = 1'b1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
